// File: rtl/qspi_xfer.sv
// Quad/dual/single SPI transfer engine: one command per accept, mode-3 SCLK
// with programmable half-period, MSB-first shifting on up to four lanes.
module qspi_xfer #(
  parameter int DW = 32,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          valid,
  output logic          ready,
  input  logic [DW-1:0] din,
  input  logic [3:0]    nbyte,
  input  logic [2:0]    format,
  input  logic          dummy,
  input  logic          last,
  input  logic [PW-1:0] prescale,
  output logic [DW-1:0] dout,
  output logic          done,
  output logic          sclk,
  output logic          cs_n,
  input  logic [3:0]    qdi,
  output logic [3:0]    qdo,
  output logic [3:0]    oe
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam logic [3:0] NB_MAX = 4'(DW / 8);
  localparam logic [6:0] DW_L   = 7'(DW);

  // Lane select encoding: 0 = single, 1 = dual, 2 = quad.
  function automatic logic [3:0] lane_out(input logic [DW-1:0] sr, input logic [1:0] lsel);
    logic [3:0] r;
    case (lsel)
      2'd0:    r = {3'b000, sr[DW-1]};
      2'd1:    r = {2'b00, sr[DW-1 -: 2]};
      default: r = sr[DW-1 -: 4];
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] tx_shift(input logic [DW-1:0] sr, input logic [1:0] lsel);
    logic [DW-1:0] r;
    case (lsel)
      2'd0:    r = sr << 1;
      2'd1:    r = sr << 2;
      default: r = sr << 4;
    endcase
    return r;
  endfunction

  // Single mode listens on qdi[1]; wider modes take qdi[L-1] as the first bit.
  function automatic logic [DW-1:0] rx_shift(input logic [DW-1:0] sr, input logic [1:0] lsel,
                                             input logic [3:0] d);
    logic [DW-1:0] r;
    case (lsel)
      2'd0:    r = {sr[DW-2:0], d[1]};
      2'd1:    r = {sr[DW-3:0], d[1:0]};
      default: r = {sr[DW-5:0], d};
    endcase
    return r;
  endfunction

  function automatic logic [3:0] oe_mask(input logic [1:0] lsel);
    logic [3:0] r;
    case (lsel)
      2'd0:    r = 4'b0001;
      2'd1:    r = 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0]    beat_q, beat_d;
  logic [DW-1:0] tx_q, tx_d;
  logic [DW-1:0] rx_q, rx_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          done_q, done_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic [3:0]    qdo_q, qdo_d;
  logic [3:0]    oe_q, oe_d;
  logic [1:0]    lsel_q, lsel_d;
  logic          rxm_q, rxm_d;
  logic          dummy_q, dummy_d;
  logic          last_q, last_d;

  logic [3:0]    nb_eff;
  logic [6:0]    nb_bits;
  logic [6:0]    beats_in;
  logic [1:0]    lsel_in;
  logic          rxm_in;
  logic [DW-1:0] tx_init;

  // Command decode, evaluated against the live inputs for the accept cycle.
  always_comb begin
    nb_eff   = (nbyte == 4'd0 || nbyte > NB_MAX) ? NB_MAX : nbyte;
    nb_bits  = {nb_eff, 3'b000};
    lsel_in  = format[2] ? (format[1] ? 2'd2 : 2'd1) : 2'd0;
    rxm_in   = format[2] & format[0];
    beats_in = nb_bits >> lsel_in;
    tx_init  = din << (DW_L - nb_bits);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    beat_d  = beat_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    qdo_d   = qdo_q;
    oe_d    = oe_q;
    lsel_d  = lsel_q;
    rxm_d   = rxm_q;
    dummy_d = dummy_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          pre_d   = prescale;
          lsel_d  = lsel_in;
          rxm_d   = rxm_in;
          dummy_d = dummy;
          last_d  = last;
          cnt_d   = '0;
          rx_d    = '0;
          if (format[2:1] == 2'b00) begin
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            beat_d  = beats_in - 7'd1;
            oe_d    = (rxm_in || dummy) ? 4'b0000 : oe_mask(lsel_in);
            state_d = S_LOW;
            if (!rxm_in) begin
              qdo_d = lane_out(tx_init, lsel_in);
              tx_d  = tx_shift(tx_init, lsel_in);
            end
          end
        end
      end

      S_LOW: begin
        if (cnt_q == pre_q) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = rx_shift(rx_q, lsel_q, qdi);
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HIGH: begin
        if (cnt_q == pre_q) begin
          cnt_d = '0;
          if (beat_q == 7'd0) begin
            done_d  = 1'b1;
            oe_d    = 4'b0000;
            state_d = S_DONE;
            if (!dummy_q) dout_d = rx_q;
            if (last_q)   cs_n_d = 1'b1;
          end else begin
            beat_d  = beat_q - 7'd1;
            sclk_d  = 1'b0;
            state_d = S_LOW;
            if (!rxm_q) begin
              qdo_d = lane_out(tx_q, lsel_q);
              tx_d  = tx_shift(tx_q, lsel_q);
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      beat_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      qdo_q   <= 4'b0000;
      oe_q    <= 4'b0000;
      lsel_q  <= 2'd0;
      rxm_q   <= 1'b0;
      dummy_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      beat_q  <= beat_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      qdo_q   <= qdo_d;
      oe_q    <= oe_d;
      lsel_q  <= lsel_d;
      rxm_q   <= rxm_d;
      dummy_q <= dummy_d;
      last_q  <= last_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign dout  = dout_q;
  assign sclk  = sclk_q;
  assign cs_n  = cs_n_q;
  assign qdo   = qdo_q;
  assign oe    = oe_q;

endmodule

// File: tb/tb_qspi_xfer.sv
// Randomized scoreboard bench for qspi_xfer: a transaction-level model predicts
// per-beat lane values and the completion record, monitors compare on sclk/done.
module tb_qspi_xfer;
  localparam int DW = 32;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [DW-1:0] din = '0;
  logic [3:0]    nbyte = 4'd0;
  logic [2:0]    format = 3'd0;
  logic          dummy = 1'b0;
  logic          last = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [DW-1:0] dout;
  logic          done;
  logic          sclk;
  logic          cs_n;
  logic [3:0]    qdi = 4'd0;
  logic [3:0]    qdo;
  logic [3:0]    oe;

  qspi_xfer #(.DW(DW), .PW(PW)) dut (
    .clk(clk), .arstn(arstn), .valid(valid), .ready(ready), .din(din),
    .nbyte(nbyte), .format(format), .dummy(dummy), .last(last),
    .prescale(prescale), .dout(dout), .done(done), .sclk(sclk),
    .cs_n(cs_n), .qdi(qdi), .qdo(qdo), .oe(oe)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;
  bit in_rst = 1'b1;
  logic [DW-1:0] model_dout = '0;
  logic          model_cs = 1'b1;

  typedef struct {
    logic [DW-1:0] dout;
    int            due;
    logic          cs;
    bit            rel;
  } done_t;

  typedef struct {
    bit         chk;
    logic [3:0] mask;
    logic [3:0] val;
    logic [3:0] oe;
  } beat_t;

  done_t      exp_q[$];
  beat_t      beat_q[$];
  logic [3:0] qdi_q[$];
  logic [3:0] fixed_pat[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Present the next planned nibble each time SCLK falls (start of a beat).
  initial forever begin
    @(negedge sclk);
    if (!in_rst) qdi = (qdi_q.size() != 0) ? qdi_q.pop_front() : 4'($urandom);
  end

  // Beat monitor: every rising SCLK must correspond to a planned beat.
  initial forever begin
    beat_t b;
    @(posedge sclk);
    if (!in_rst) begin
      if (beat_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_sclk: got rising sclk expected none at edge %0d", edge_n);
      end else begin
        b = beat_q.pop_front();
        chk("beat_oe", oe, b.oe);
        if (b.chk) chk("beat_qdo", qdo & b.mask, b.val);
      end
    end
  end

  // Completion monitor.
  initial forever begin
    done_t e;
    @(negedge clk);
    if (!in_rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected 0 at edge %0d", edge_n);
      end else begin
        e = exp_q.pop_front();
        chk("done_latency", edge_n + 1, e.due);
        chk("done_cs_n", cs_n, e.cs);
        chk("done_oe", oe, 4'b0000);
        chk("done_beats_left", beat_q.size(), 0);
        if (!e.rel) chk("done_dout", dout, e.dout);
      end
    end
  end

  task automatic start_cmd(input logic [DW-1:0] d, input logic [3:0] nbv, input logic [2:0] fmt,
                           input logic dmy, input logic lst, input logic [PW-1:0] pre);
    int guard, nb, lanes_n, beats, mask, acc;
    bit rel, rxm;
    logic [DW-1:0] rxv;
    logic [3:0] nib, lanes, oev;
    beat_t b;
    done_t e;
    guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      $display("FAIL ready_timeout: got ready=%0b expected 1", ready);
      $fatal(1, "engine never returned to idle");
    end
    chk("idle_cs_n", cs_n, model_cs);
    chk("idle_oe", oe, 4'b0000);
    acc = edge_n + 1;

    nb      = (nbv == 0 || nbv > DW / 8) ? DW / 8 : int'(nbv);
    rel     = (fmt[2:1] == 2'b00);
    lanes_n = fmt[2] ? (fmt[1] ? 4 : 2) : 1;
    rxm     = fmt[2] & fmt[0];
    beats   = nb * 8 / lanes_n;
    mask    = (1 << lanes_n) - 1;
    oev     = (rxm || dmy) ? 4'b0000 : 4'(mask);
    if (rel) begin
      e.dout = model_dout; e.due = acc + 1; e.cs = 1'b1; e.rel = 1'b1;
      exp_q.push_back(e);
      model_cs = 1'b1;
    end else begin
      rxv = '0;
      for (int i = 0; i < beats; i++) begin
        nib = (fixed_pat.size() != 0) ? fixed_pat.pop_front() : 4'($urandom);
        qdi_q.push_back(nib);
        lanes = (lanes_n == 1) ? {3'b000, nib[1]} : (nib & 4'(mask));
        rxv = (rxv << lanes_n) | DW'(lanes);
        b.chk  = !rxm && !dmy;
        b.mask = 4'(mask);
        b.val  = 4'((d >> (8 * nb - (i + 1) * lanes_n)) & DW'(mask));
        b.oe   = oev;
        beat_q.push_back(b);
      end
      if (!dmy) model_dout = rxv;
      e.dout = model_dout; e.due = acc + 2 * beats * (int'(pre) + 1) + 1; e.cs = lst; e.rel = 1'b0;
      exp_q.push_back(e);
      model_cs = lst;
    end

    din = d; nbyte = nbv; format = fmt; dummy = dmy; last = lst; prescale = pre;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Waits for done while scribbling on every input to prove they are ignored.
  task automatic wait_done();
    int g;
    g = 0;
    while (done !== 1'b1 && g < 3000) begin
      valid = 1'($urandom); din = DW'({$urandom(), $urandom()}); nbyte = 4'($urandom);
      format = 3'($urandom); dummy = 1'($urandom); last = 1'($urandom);
      prescale = PW'($urandom);
      @(negedge clk);
      g++;
    end
    valid = 1'b0;
    if (g >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_qdo", qdo, 4'b0000);
    chk("rst_oe", oe, 4'b0000);
    chk("rst_dout", dout, 0);
    arstn = 1'b1;
    in_rst = 1'b0;

    // Single, 0xA5 out, 0x3C in on qdi[1].
    fixed_pat = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
    start_cmd(DW'(32'hA5), 4'd1, 3'b010, 1'b0, 1'b1, 8'd0);
    wait_done();
    chk("single_dout_3c", dout, DW'(32'h3C));

    // Quad rx, nibbles 1..8.
    fixed_pat = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    start_cmd('0, 4'd4, 3'b111, 1'b0, 1'b1, 8'd1);
    wait_done();
    chk("quad_dout", dout, DW'(32'h12345678));

    // Two-command frame: cs_n held low in between.
    start_cmd(DW'(32'h06), 4'd1, 3'b110, 1'b0, 1'b0, 8'd0);
    wait_done();
    start_cmd(DW'($urandom), 4'd1, 3'b011, 1'b0, 1'b1, 8'd0);
    wait_done();

    // Dummy quad byte.
    start_cmd(DW'($urandom), 4'd1, 3'b110, 1'b1, 1'b1, 8'd0);
    wait_done();

    // Release with cs_n low.
    start_cmd(DW'($urandom), 4'd2, 3'b010, 1'b0, 1'b0, 8'd2);
    wait_done();
    start_cmd(DW'($urandom), 4'd1, 3'b000, 1'b0, 1'b0, 8'd0);
    wait_done();

    // Slowest SCLK.
    start_cmd(DW'($urandom), 4'd1, 3'b110, 1'b0, 1'b1, 8'd255);
    wait_done();

    // Abort mid-beat.
    start_cmd(DW'($urandom), 4'd4, 3'b111, 1'b0, 1'b1, 8'd1);
    repeat (9) @(negedge clk);
    in_rst = 1'b1;
    arstn = 1'b0;
    #1;
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_sclk", sclk, 1'b1);
    chk("abort_cs_n", cs_n, 1'b1);
    chk("abort_qdo", qdo, 4'b0000);
    chk("abort_oe", oe, 4'b0000);
    chk("abort_dout", dout, 0);
    exp_q.delete();
    beat_q.delete();
    qdi_q.delete();
    model_dout = '0;
    model_cs = 1'b1;
    @(negedge clk);
    arstn = 1'b1;
    in_rst = 1'b0;
    repeat (60) @(negedge clk);
    start_cmd(DW'($urandom), 4'd2, 3'b100, 1'b0, 1'b1, 8'd0);
    wait_done();

    for (int k = 0; k < 40; k++) begin
      start_cmd(DW'($urandom), 4'($urandom_range(0, 15)), 3'($urandom), ($urandom % 5) == 0,
                1'($urandom), PW'($urandom_range(0, 3)));
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("end_exp_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_xfer.md
QSPI_XFER -- requirements
Module: qspi_xfer

Interface
REQ-001 SHALL have parameter DW, default 32: transfer word width in bits; a multiple of 8, range 8..64.
REQ-002 SHALL have parameter PW, default 8: prescale field width in bits.
REQ-003 clk  input  1  module clock.
REQ-004 arstn  input  1  reset, asynchronous, active-low.
REQ-005 valid  input  1  command strobe; the command is accepted on a cycle where valid=1 and ready=1.
REQ-006 ready  output  1  engine is idle and can accept a command.
REQ-007 din  input  DW  transmit word, right-aligned.
REQ-008 nbyte  input  4  bytes to shift, 1..DW/8; 0 or any value above DW/8 SHALL be treated as DW/8.
REQ-009 format  input  3  bus format: 00x release CS; 01x single; 100 dual tx; 101 dual rx; 110 quad tx; 111 quad rx.
REQ-010 dummy  input  1  clocks SCLK with oe=0 and discards received data.
REQ-011 last  input  1  deassert cs_n after this command.
REQ-012 prescale  input  PW  SCLK half-period, in clk cycles, is prescale+1.
REQ-013 dout  output  DW  received word, right-aligned, upper bits zero.
REQ-014 done  output  1  one-cycle pulse when a command completes.
REQ-015 sclk  output  1  SPI clock; idles high (mode 3).
REQ-016 cs_n  output  1  chip select, registered.
REQ-017 qdi  input  4  SPI data in.
REQ-018 qdo  output  4  SPI data out.
REQ-019 oe  output  4  per-lane output enable for qdo.

Function
REQ-020 SHALL sample din, nbyte, format, dummy, last and prescale at acceptance; input changes during a command SHALL have no effect.
REQ-021 State machine IDLE->LOW->HIGH->(LOW|DONE)->IDLE; ready=1 only in IDLE.
REQ-022 Lanes per beat: L=1 for 01x, L=2 for 10x, L=4 for 11x; beats B = nbyte*8/L.
REQ-023 Accept with format 01x-11x: cs_n<=0, and the state SHALL go to LOW.
REQ-024 Entering LOW: sclk<=0; for tx and single formats, qdo[L-1:0] SHALL take the next L MSB-first bits of din[8*nbyte-1:0] on the same edge.
REQ-025 LOW SHALL last prescale+1 cycles, then enter HIGH with sclk<=1; qdi[L-1:0] SHALL be shifted into the receive register on that edge.
REQ-026 Single mode SHALL transmit on qdo[0] and receive on qdi[1]; dual/quad modes SHALL receive on qdi[L-1:0], MSB-lane first.
REQ-027 HIGH SHALL last prescale+1 cycles; after beat B it SHALL enter DONE, otherwise LOW.
REQ-028 DONE (1 cycle): done=1; dout SHALL load the received bits unless dummy=1, in which case dout SHALL hold; if last=1, cs_n<=1; then IDLE.
REQ-029 Latency: done SHALL assert exactly 2*B*(prescale+1)+1 cycles after the accept edge.
REQ-030 Accept with format 00x: no SCLK toggles; cs_n<=1 and done SHALL pulse on the next cycle.
REQ-031 oe SHALL be 0000 in IDLE, in DONE, in rx formats and when dummy=1; otherwise 0001 (single), 0011 (dual tx) or 1111 (quad tx).
REQ-032 cs_n SHALL remain low between commands while last=0, allowing multi-command frames.
REQ-033 qdo SHALL hold its last value while in IDLE.
REQ-034 valid while ready=0 SHALL be ignored; no queuing.
REQ-035 prescale=0 SHALL give SCLK = clk/2; prescale at maximum SHALL give a half-period of 2^PW cycles.

Reset
REQ-036 arstn low, at any time including mid-command: state=IDLE, ready=1, done=0, sclk=1, cs_n=1, qdo=0, oe=0, dout=0, counters=0.
REQ-037 An aborted command SHALL NOT produce done after reset release.

Verification
REQ-038 Single, nbyte=1, din=0xA5, prescale=0, last=1: qdo[0] sequence 1,0,1,0,0,1,0,1; qdi[1] pattern 0x3C gives dout=0x3C; done at cycle 17; cs_n high after.
REQ-039 Quad rx, nbyte=4, prescale=1, qdi nibbles 1..8: dout=0x12345678; done at cycle 33; oe=0 throughout.
REQ-040 Quad tx 0x06 last=0, then single rx nbyte=1 last=1: cs_n stays low between the two commands, then rises after the second done.
REQ-041 dummy=1, quad, nbyte=1: 2 SCLK periods, oe=0, dout unchanged.
REQ-042 arstn pulsed mid-beat: all outputs at reset values immediately; no done pulse afterwards; the next command runs normally.
REQ-043 format=000 with cs_n low: cs_n=1 and done pulse on the next cycle; sclk never toggles.
